board_win_scan: RTL and testbench

BOARD_WIN_SCAN -- requirements
Module: board_win_scan

---
 rtl/board_pkg.sv | 25 ++
 rtl/run_counter.sv | 68 ++++++
 rtl/board_win_scan.sv | 152 +++++++++++++++
 tb/tb_board_win_scan.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared cell, state and scan-direction types for board_win_scan
package board_pkg;

    // Cell encoding doubles as the player encoding on cur_player and winner.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Scan order: horizontal, vertical, diagonal, anti-diagonal.
    typedef enum logic [1:0] {
        H = 2'd0,
        V = 2'd1,
        D = 2'd2,
        A = 2'd3
    } dir_t;

endpackage

// File: rtl/run_counter.sv
// rtl/run_counter.sv - combinational run length through one cell along one direction
//
// Ports:
//   board   : N*N cells, 2 bits each, index row*N+col
//   row/col : cell the run must pass through (assumed to hold player)
//   dir     : H, V, D (down-right) or A (down-left)
//   player  : cell value being counted
//   run_len : contiguous same-player cells including row/col, clipped at edges, capped at K
module run_counter
    import board_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3,
    localparam int RW = $clog2(N),
    localparam int CW = $clog2(K + 1)
) (
    input  logic [N*N-1:0][1:0] board,
    input  logic [RW-1:0]       row,
    input  logic [RW-1:0]       col,
    input  dir_t                dir,
    input  logic [1:0]          player,
    output logic [CW-1:0]       run_len
);

    localparam int CI = $clog2(N * N);

    int   dr;
    int   dc;
    int   r;
    int   c;
    int   total;
    logic go;

    always_comb begin
        dr    = 0;
        dc    = 1;
        r     = 0;
        c     = 0;
        total = 1;
        go    = 1'b0;
        case (dir)
            H:       begin dr = 0; dc = 1;  end
            V:       begin dr = 1; dc = 0;  end
            D:       begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        // Walk away from the cell in both senses; only K-1 steps each way
        // can matter because the result saturates at K.
        for (int sgn = -1; sgn <= 1; sgn += 2) begin
            go = 1'b1;
            for (int s = 1; s < K; s++) begin
                r = int'(row) + sgn * s * dr;
                c = int'(col) + sgn * s * dc;
                if (go && r >= 0 && r < N && c >= 0 && c < N) begin
                    if (board[CI'(r * N + c)] == player) begin
                        total = total + 1;
                    end else begin
                        go = 1'b0;
                    end
                end else begin
                    go = 1'b0;
                end
            end
        end
        run_len = (total >= K) ? CW'(K) : CW'(total);
    end

endmodule

// File: rtl/board_win_scan.sv
// rtl/board_win_scan.sv - N x N board with move handshake and 4-cycle K-in-a-row scan
//
// Ports:
//   clock, reset (async active-low), new_game (sync clear)
//   move_valid/move_ready/move_row/move_col : move handshake; move_err pulses on rejects
//   cur_player    : player to move (01=P1, 10=P2)
//   result_valid  : one-cycle pulse after the 4th scan edge
//   game_over, winner, draw, move_count : game status
//   rd_row/rd_col/rd_cell : combinational display read, 00 when out of range
module board_win_scan
    import board_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3,
    localparam int RW  = $clog2(N),
    localparam int MCW = $clog2(N * N + 1)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           new_game,
    input  logic           move_valid,
    input  logic [RW-1:0]  move_row,
    input  logic [RW-1:0]  move_col,
    output logic           move_ready,
    output logic           move_err,
    output logic [1:0]     cur_player,
    output logic           result_valid,
    output logic           game_over,
    output logic [1:0]     winner,
    output logic           draw,
    output logic [MCW-1:0] move_count,
    input  logic [RW-1:0]  rd_row,
    input  logic [RW-1:0]  rd_col,
    output logic [1:0]     rd_cell
);

    localparam int             CI    = $clog2(N * N);
    localparam int             CW    = $clog2(K + 1);
    // One extra bit so N itself is representable when N is a power of two.
    localparam logic [RW:0]    N_LIM = N[RW:0];

    logic [N*N-1:0][1:0] board;
    state_t              state;
    dir_t                dir;
    logic [RW-1:0]       lat_row;
    logic [RW-1:0]       lat_col;
    logic                hit;
    logic [CW-1:0]       run_len;
    logic                hit_now;
    logic                mv_in_range;
    logic                mv_ok;
    logic [CI-1:0]       mv_idx;
    logic                rd_in_range;
    logic [CI-1:0]       rd_idx;

    assign mv_in_range = ({1'b0, move_row} < N_LIM) && ({1'b0, move_col} < N_LIM);
    assign mv_idx      = CI'(int'(move_row) * N + int'(move_col));
    assign mv_ok       = mv_in_range && (board[mv_idx] == EMPTY);

    assign rd_in_range = ({1'b0, rd_row} < N_LIM) && ({1'b0, rd_col} < N_LIM);
    assign rd_idx      = CI'(int'(rd_row) * N + int'(rd_col));
    assign rd_cell     = rd_in_range ? board[rd_idx] : 2'b00;

    assign move_ready  = (state == IDLE) && !new_game;
    assign hit_now     = (run_len >= CW'(K));

    run_counter #(
        .N (N),
        .K (K)
    ) u_run_counter (
        .board   (board),
        .row     (lat_row),
        .col     (lat_col),
        .dir     (dir),
        .player  (cur_player),
        .run_len (run_len)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            board        <= '0;
            state        <= IDLE;
            dir          <= H;
            lat_row      <= '0;
            lat_col      <= '0;
            hit          <= 1'b0;
            cur_player   <= P1;
            move_count   <= '0;
            winner       <= EMPTY;
            draw         <= 1'b0;
            game_over    <= 1'b0;
            move_err     <= 1'b0;
            result_valid <= 1'b0;
        end else if (new_game) begin
            // Wins over any concurrent move and aborts an in-flight scan.
            board        <= '0;
            state        <= IDLE;
            dir          <= H;
            hit          <= 1'b0;
            cur_player   <= P1;
            move_count   <= '0;
            winner       <= EMPTY;
            draw         <= 1'b0;
            game_over    <= 1'b0;
            move_err     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            move_err     <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (move_valid) begin
                        if (mv_ok) begin
                            board[mv_idx] <= cur_player;
                            move_count    <= move_count + 1'b1;
                            lat_row       <= move_row;
                            lat_col       <= move_col;
                            dir           <= H;
                            hit           <= 1'b0;
                            state         <= SCAN;
                        end else begin
                            move_err <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    dir <= dir_t'(dir + 2'd1);
                    hit <= hit | hit_now;
                    // Last direction: the verdict must include this cycle's hit.
                    if (dir == A) begin
                        result_valid <= 1'b1;
                        if (hit || hit_now) begin
                            winner    <= cur_player;
                            game_over <= 1'b1;
                            state     <= DONE;
                        end else if (move_count == MCW'(N * N)) begin
                            draw      <= 1'b1;
                            game_over <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cur_player <= (cur_player == P1) ? P2 : P1;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_win_scan.sv
// tb/tb_board_win_scan.sv - self-checking bench for board_win_scan (N=3/K=3 and N=5/K=4)
module tb_board_win_scan;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       new_game;
    logic       move_valid;
    logic [2:0] mr;
    logic [2:0] mc;
    logic [2:0] rr;
    logic [2:0] rc;
    logic       sel;

    logic       rdy3, err3, rv3, over3, draw3;
    logic [1:0] cp3, win3, cell3;
    logic [3:0] cnt3;
    logic       rdy5, err5, rv5, over5, draw5;
    logic [1:0] cp5, win5, cell5;
    logic [4:0] cnt5;

    board_win_scan #(.N(3), .K(3)) u_dut3 (
        .clock (clock), .reset (reset), .new_game (new_game), .move_valid (move_valid),
        .move_row (mr[1:0]), .move_col (mc[1:0]), .move_ready (rdy3), .move_err (err3),
        .cur_player (cp3), .result_valid (rv3), .game_over (over3), .winner (win3),
        .draw (draw3), .move_count (cnt3), .rd_row (rr[1:0]), .rd_col (rc[1:0]), .rd_cell (cell3)
    );

    board_win_scan #(.N(5), .K(4)) u_dut5 (
        .clock (clock), .reset (reset), .new_game (new_game), .move_valid (move_valid),
        .move_row (mr), .move_col (mc), .move_ready (rdy5), .move_err (err5),
        .cur_player (cp5), .result_valid (rv5), .game_over (over5), .winner (win5),
        .draw (draw5), .move_count (cnt5), .rd_row (rr), .rd_col (rc), .rd_cell (cell5)
    );

    logic       o_ready, o_err, o_rv, o_over, o_draw;
    logic [1:0] o_cp, o_win, o_cell;
    logic [4:0] o_count;
    assign o_ready = sel ? rdy5  : rdy3;
    assign o_err   = sel ? err5  : err3;
    assign o_rv    = sel ? rv5   : rv3;
    assign o_over  = sel ? over5 : over3;
    assign o_draw  = sel ? draw5 : draw3;
    assign o_cp    = sel ? cp5   : cp3;
    assign o_win   = sel ? win5  : win3;
    assign o_cell  = sel ? cell5 : cell3;
    assign o_count = sel ? cnt5  : {1'b0, cnt3};

    // Reference model: plain game rules on a 2-D array.
    int mb [8][8];
    int mn, mk, mplayer, mcount, mwinner;
    bit mdraw, mover;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void model_clear();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mb[r][c] = 0;
        mplayer = 1; mcount = 0; mwinner = 0; mdraw = 0; mover = 0;
    endfunction

    // Brute force: does any K-long straight line anywhere belong entirely to p?
    function automatic bit model_win(input int p);
        int drs [4];
        int dcs [4];
        int rx, cx;
        bit all;
        drs = '{0, 1, 1, 1};
        dcs = '{1, 0, 1, -1};
        for (int d = 0; d < 4; d++)
            for (int r0 = 0; r0 < mn; r0++)
                for (int c0 = 0; c0 < mn; c0++) begin
                    all = 1;
                    for (int s = 0; s < mk; s++) begin
                        rx = r0 + s * drs[d];
                        cx = c0 + s * dcs[d];
                        if (rx < 0 || rx >= mn || cx < 0 || cx >= mn) all = 0;
                        else if (mb[rx][cx] != p) all = 0;
                    end
                    if (all) return 1;
                end
        return 0;
    endfunction

    task automatic new_game_pulse();
        @(negedge clock);
        new_game = 1'b1; move_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        new_game = 1'b0;
        model_clear();
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL ng_ready: got %b want 1", o_ready); end
        n_cmp++; if (o_count !== 5'd0) begin n_bad++; $display("FAIL ng_count: got %0d want 0", o_count); end
        n_cmp++; if (o_cp !== 2'b01) begin n_bad++; $display("FAIL ng_player: got %b want 01", o_cp); end
        n_cmp++; if (o_over !== 1'b0) begin n_bad++; $display("FAIL ng_over: got %b want 0", o_over); end
    endtask

    task automatic drive_move(input int r, input int c);
        int lat;
        int p;
        bit ok;
        p  = mplayer;
        ok = (r < mn) && (c < mn) && (mb[r][c] == 0);
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL mv_ready_pre: got %b want 1", o_ready); end
        move_valid = 1'b1; mr = 3'(r); mc = 3'(c);
        @(posedge clock);
        @(negedge clock);
        move_valid = 1'b0;
        if (!ok) begin
            n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL err_pulse (%0d,%0d): got %b want 1", r, c, o_err); end
            n_cmp++; if (o_cp !== 2'(p)) begin n_bad++; $display("FAIL err_player: got %b want %0d", o_cp, p); end
            n_cmp++; if (o_count !== 5'(mcount)) begin n_bad++; $display("FAIL err_count: got %0d want %0d", o_count, mcount); end
            n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL err_ready: got %b want 1", o_ready); end
            @(negedge clock);
            n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL err_single: got %b want 0", o_err); end
        end else begin
            mb[r][c] = p;
            mcount++;
            rr = 3'(r); rc = 3'(c);
            #1;
            n_cmp++; if (o_cell !== 2'(p)) begin n_bad++; $display("FAIL rd_after_write (%0d,%0d): got %b want %0d", r, c, o_cell, p); end
            n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL scan_ready: got %b want 0", o_ready); end
            n_cmp++; if (o_count !== 5'(mcount)) begin n_bad++; $display("FAIL mv_count: got %0d want %0d", o_count, mcount); end
            lat = 0;
            while (o_rv !== 1'b1 && lat < 12) begin @(negedge clock); lat++; end
            n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL rv_latency: got %0d want 4", lat); end
            if (model_win(p)) begin mwinner = p; mover = 1; end
            else if (mcount == mn * mn) begin mdraw = 1; mover = 1; end
            else mplayer = 3 - p;
            n_cmp++; if (o_win !== 2'(mwinner)) begin n_bad++; $display("FAIL winner: got %b want %0d", o_win, mwinner); end
            n_cmp++; if (o_draw !== mdraw) begin n_bad++; $display("FAIL draw: got %b want %b", o_draw, mdraw); end
            n_cmp++; if (o_over !== mover) begin n_bad++; $display("FAIL game_over: got %b want %b", o_over, mover); end
            n_cmp++; if (o_cp !== 2'(mplayer)) begin n_bad++; $display("FAIL cur_player: got %b want %0d", o_cp, mplayer); end
            n_cmp++; if (o_ready !== !mover) begin n_bad++; $display("FAIL post_ready: got %b want %b", o_ready, !mover); end
            @(negedge clock);
            n_cmp++; if (o_rv !== 1'b0) begin n_bad++; $display("FAIL rv_single: got %b want 0", o_rv); end
        end
    endtask

    task automatic check_board();
        int lim;
        int exp;
        lim = sel ? 7 : 3;
        for (int r = 0; r <= lim; r++)
            for (int c = 0; c <= lim; c++) begin
                rr = 3'(r); rc = 3'(c);
                #1;
                exp = (r < mn && c < mn) ? mb[r][c] : 0;
                n_cmp++; if (o_cell !== 2'(exp)) begin n_bad++; $display("FAIL rd_cell (%0d,%0d): got %b want %0d", r, c, o_cell, exp); end
            end
    endtask

    task automatic use_dut(input bit s);
        sel = s;
        mn  = s ? 5 : 3;
        mk  = s ? 4 : 3;
    endtask

    task automatic test_reset();
        reset = 1'b0; new_game = 1'b0; move_valid = 1'b0;
        mr = '0; mc = '0; rr = '0; rc = '0;
        use_dut(0);
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_cmp++; if (o_cp !== 2'b01) begin n_bad++; $display("FAIL rst_player[%0d]: got %b want 01", s, o_cp); end
            n_cmp++; if (o_count !== 5'd0) begin n_bad++; $display("FAIL rst_count[%0d]: got %0d want 0", s, o_count); end
            n_cmp++; if ({o_err, o_rv, o_over, o_draw, o_win} !== 6'd0) begin n_bad++; $display("FAIL rst_status[%0d]: got %b want 000000", s, {o_err, o_rv, o_over, o_draw, o_win}); end
            n_cmp++; if (o_cell !== 2'b00) begin n_bad++; $display("FAIL rst_cell[%0d]: got %b want 00", s, o_cell); end
        end
        @(negedge clock);
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready[%0d]: got %b want 1", s, o_ready); end
        end
        use_dut(0);
        model_clear();
    endtask

    task automatic test_row_win();
        use_dut(0);
        new_game_pulse();
        drive_move(0, 0); drive_move(1, 0); drive_move(0, 1); drive_move(1, 1); drive_move(0, 2);
        n_cmp++; if (o_win !== 2'b01 || o_over !== 1'b1 || o_ready !== 1'b0) begin n_bad++; $display("FAIL row_win: got win=%b over=%b ready=%b want 01/1/0", o_win, o_over, o_ready); end
        // Moves are ignored silently once the game is finished.
        move_valid = 1'b1; mr = 3'd2; mc = 3'd2;
        repeat (2) @(posedge clock);
        @(negedge clock);
        move_valid = 1'b0;
        rr = 3'd2; rc = 3'd2;
        #1;
        n_cmp++; if (o_err !== 1'b0 || o_count !== 5'd5 || o_cell !== 2'b00) begin n_bad++; $display("FAIL done_ignore: got err=%b count=%0d cell=%b want 0/5/00", o_err, o_count, o_cell); end
    endtask

    task automatic test_draw();
        use_dut(0);
        new_game_pulse();
        drive_move(0, 0); drive_move(0, 1); drive_move(0, 2); drive_move(1, 1); drive_move(1, 0);
        drive_move(2, 0); drive_move(2, 1); drive_move(1, 2); drive_move(2, 2);
        n_cmp++; if (o_draw !== 1'b1 || o_win !== 2'b00 || o_count !== 5'd9) begin n_bad++; $display("FAIL draw_game: got draw=%b win=%b count=%0d want 1/00/9", o_draw, o_win, o_count); end
        check_board();
    endtask

    task automatic test_illegal();
        use_dut(0);
        new_game_pulse();
        drive_move(0, 0);
        drive_move(0, 0);
        drive_move(3, 0);
        drive_move(1, 3);
        n_cmp++; if (o_cp !== 2'b10 || o_count !== 5'd1) begin n_bad++; $display("FAIL illegal_state: got player=%b count=%0d want 10/1", o_cp, o_count); end
    endtask

    task automatic test_k4_antidiag();
        use_dut(1);
        new_game_pulse();
        drive_move(4, 0); drive_move(0, 4); drive_move(4, 1); drive_move(1, 3); drive_move(4, 2);
        n_cmp++; if (o_over !== 1'b0) begin n_bad++; $display("FAIL three_run_no_win: got over=%b want 0", o_over); end
        drive_move(2, 2); drive_move(0, 0); drive_move(3, 1);
        n_cmp++; if (o_win !== 2'b10 || o_over !== 1'b1) begin n_bad++; $display("FAIL antidiag_win: got win=%b over=%b want 10/1", o_win, o_over); end
        check_board();
        use_dut(0);
    endtask

    task automatic test_newgame_midscan();
        bit seen;
        use_dut(0);
        new_game_pulse();
        move_valid = 1'b1; mr = 3'd0; mc = 3'd0;
        @(posedge clock);
        @(negedge clock);
        move_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        new_game = 1'b1; move_valid = 1'b1; mr = 3'd1; mc = 3'd1;
        @(posedge clock);
        @(negedge clock);
        seen = (o_rv === 1'b1);
        new_game = 1'b0; move_valid = 1'b0;
        model_clear();
        #1;
        n_cmp++; if (o_ready !== 1'b1 || o_cp !== 2'b01 || o_count !== 5'd0) begin n_bad++; $display("FAIL ng_mid_state: got ready=%b player=%b count=%0d want 1/01/0", o_ready, o_cp, o_count); end
        check_board();
        for (int i = 0; i < 6; i++) begin @(negedge clock); if (o_rv === 1'b1) seen = 1; end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL ng_mid_rv: got result_valid=1 want none"); end
    endtask

    task automatic test_reset_midgame();
        bit seen;
        use_dut(0);
        new_game_pulse();
        drive_move(0, 0);
        move_valid = 1'b1; mr = 3'd1; mc = 3'd1;
        @(posedge clock);
        @(negedge clock);
        move_valid = 1'b0;
        @(posedge clock);
        #2 reset = 1'b0;
        rr = 3'd0; rc = 3'd0;
        #1;
        n_cmp++; if (o_cp !== 2'b01 || o_count !== 5'd0) begin n_bad++; $display("FAIL async_rst_state: got player=%b count=%0d want 01/0", o_cp, o_count); end
        n_cmp++; if ({o_err, o_rv, o_over, o_draw, o_win} !== 6'd0) begin n_bad++; $display("FAIL async_rst_status: got %b want 000000", {o_err, o_rv, o_over, o_draw, o_win}); end
        n_cmp++; if (o_cell !== 2'b00) begin n_bad++; $display("FAIL async_rst_cell: got %b want 00", o_cell); end
        @(negedge clock);
        reset = 1'b1;
        model_clear();
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst_ready: got %b want 1", o_ready); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clock); if (o_rv === 1'b1) seen = 1; end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL async_rst_rv: got result_valid=1 want none"); end
        check_board();
    endtask

    task automatic test_random_games();
        int r, c, lim, tries;
        for (int s = 0; s < 2; s++) begin
            use_dut(s[0]);
            lim = s ? 7 : 3;
            for (int g = 0; g < 5; g++) begin
                new_game_pulse();
                tries = 0;
                while (!mover && tries < 150) begin
                    if ($urandom_range(0, 7) == 0) begin
                        r = int'($urandom_range(0, lim)); c = int'($urandom_range(0, lim));
                    end else begin
                        r = int'($urandom_range(0, mn - 1)); c = int'($urandom_range(0, mn - 1));
                    end
                    drive_move(r, c);
                    tries++;
                end
                check_board();
            end
        end
        use_dut(0);
    endtask

    initial begin
        test_reset();
        test_row_win();
        test_draw();
        test_illegal();
        test_k4_antidiag();
        test_newgame_midscan();
        test_reset_midgame();
        test_random_games();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
